// File: rtl/grain_cipher_ctrl_if.sv
// Byte-stream host interface for grain_cipher_ctrl.
// The master side is the host: it drives the input words and accepts the results.
// The slave side is the controller: it takes the input words and produces the results.
interface grain_cipher_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/grain_cipher_ctrl.sv
// Sequencer for an 80-bit Grain keystream core.
//
// Flow: the seed is loaded, then the core runs the warm-up rounds whose keystream is thrown
// away. After that, each host word is XORed with DATA_W keystream bits, least significant
// bit first.
//
// Optional feature: define GRAIN_CTRL_WORD_CNT_EN to add the word_cnt_o port. It is a
// 16-bit count of completed output handshakes since the last seed load, and it saturates
// at 16'hFFFF.
module grain_cipher_ctrl #(
  parameter int unsigned INIT_CYCLES = 160,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [79:0]         key_in_i,
  output logic [79:0]         ks_seed_o,
  output logic                ks_load_o,
  output logic                ks_shift_o,
  input  logic                ks_bit_i,
  grain_cipher_ctrl_if.slave  host_if,
  output logic                keyed_o
`ifdef GRAIN_CTRL_WORD_CNT_EN
  ,
  output logic [15:0]         word_cnt_o
`endif
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_W - 1);
  // A value of INIT_CYCLES == 0 never reaches WARMUP, so the wrapped value is never used.
  localparam logic [CNT_W-1:0] WarmLast = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWarmup,
    StRun,
    StXor,
    StOut
  } state_e;

  state_e            state_q, state_d;
  logic [79:0]       seed_q, seed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;

  // State and datapath registers, with a synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      seed_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // Next-state logic and datapath updates.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        // start beats stop here; stop only has meaning in RUN.
        if (start_i) begin
          seed_d  = key_in_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = (INIT_CYCLES == 0) ? StRun : StWarmup;
      end
      StWarmup: begin
        if (cnt_q == WarmLast) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (host_if.in_valid) begin
          data_d  = host_if.in_data;
          idx_d   = '0;
          state_d = StXor;
        end
      end
      StXor: begin
        // ks_bit_i is this cycle's keystream bit; the core advances on this same edge.
        result_d[idx_q] = data_q[idx_q] ^ ks_bit_i;
        if (idx_q == IdxLast) begin
          state_d = StOut;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        if (host_if.out_ready) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode. All the 1-bit outputs are low in IDLE.
  always_comb begin
    ks_seed_o          = seed_q;
    ks_load_o          = (state_q == StLoad);
    ks_shift_o         = (state_q == StWarmup) || (state_q == StXor);
    host_if.in_ready   = (state_q == StRun);
    host_if.out_valid  = (state_q == StOut);
    host_if.out_data   = result_q;
    keyed_o            = (state_q == StRun) || (state_q == StXor) || (state_q == StOut);
  end

`ifdef GRAIN_CTRL_WORD_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Count completed result handshakes; the count restarts on each seed load.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (state_q == StLoad) begin
      word_cnt_d = '0;
    end else if ((state_q == StOut) && host_if.out_ready && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  // Word counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_grain_cipher_ctrl.sv
// Self-checking bench for grain_cipher_ctrl (INIT_CYCLES=4, DATA_W=8).
// The keystream comes from a behavioural 80-bit shift-register core. Expected result words
// are computed from that core's model and queued when a word is accepted.
module tb_grain_cipher_ctrl;
  localparam int unsigned InitCycles = 4;
  localparam int unsigned DataW      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [79:0] key_in;
  logic [79:0] ks_seed;
  logic        ks_load, ks_shift, ks_bit;
  logic        keyed;
  logic        force_one;
`ifdef GRAIN_CTRL_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] sb[$];

  grain_cipher_ctrl_if #(.DATA_W(DataW)) bus ();

  grain_cipher_ctrl #(
    .INIT_CYCLES(InitCycles),
    .DATA_W     (DataW),
    .CNT_W      (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .stop_i    (stop),
    .key_in_i  (key_in),
    .ks_seed_o (ks_seed),
    .ks_load_o (ks_load),
    .ks_shift_o(ks_shift),
    .ks_bit_i  (ks_bit),
    .host_if   (bus),
    .keyed_o   (keyed)
`ifdef GRAIN_CTRL_WORD_CNT_EN
    ,
    .word_cnt_o(word_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural keystream core
  function automatic logic [79:0] core_step(input logic [79:0] s);
    return {s[0] ^ s[13] ^ s[23] ^ s[38] ^ s[51] ^ s[62], s[79:1]};
  endfunction

  function automatic logic core_out(input logic [79:0] s);
    return s[0] ^ (s[3] & s[25]) ^ s[46];
  endfunction

  function automatic logic [7:0] ks_word(input logic [79:0] seed, input int skip);
    logic [79:0] s;
    logic [7:0]  w;
    s = seed;
    for (int i = 0; i < skip; i++) s = core_step(s);
    for (int i = 0; i < 8; i++) begin
      w[i] = core_out(s);
      s = core_step(s);
    end
    return w;
  endfunction

  logic [79:0] core_q = '0;
  always @(posedge clk) begin
    if (ks_load) core_q <= ks_seed;
    else if (ks_shift) core_q <= core_step(core_q);
  end
  assign ks_bit = force_one ? 1'b1 : core_out(core_q);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; key_in = '0; force_one = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (n) tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic key_up(input logic [79:0] key);
    int n;
    start = 1'b1; key_in = key;
    tick();
    start = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 400) begin tick(); n++; end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL key_up_timeout: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  // Send one word, wait for its result and hold out_ready low for 'hold' cycles.
  task automatic run_word(input logic [7:0] data, input logic [7:0] exp, input int hold,
                          output int acc_cyc);
    int n;
    int lat;
    logic [7:0] want;
    acc_cyc = 0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL word_ready_timeout: in_ready=%b want 1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1; bus.in_data = data; bus.out_ready = (hold == 0);
    tick();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    sb.push_back(exp);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
    n_tests++;
    if (lat != DataW) begin
      n_fail++; $display("FAIL out_latency: got %0d cycles want %0d", lat, DataW);
    end
    for (int i = 0; i < hold; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
        n_fail++;
        $display("FAIL out_hold[%0d]: valid=%b data=%h want 1/%h", i, bus.out_valid,
                 bus.out_data, exp);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty: size=0 want >0");
    end else begin
      want = sb.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
        n_fail++;
        $display("FAIL out_word: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, want);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if ({ks_load, ks_shift, bus.in_ready, bus.out_valid, keyed} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: load/shift/ready/valid/keyed=%b want 00000",
               {ks_load, ks_shift, bus.in_ready, bus.out_valid, keyed});
    end
    n_tests++;
    if (ks_seed !== 80'h0 || bus.out_data !== 8'h0) begin
      n_fail++; $display("FAIL reset_data: seed=%h out=%h want 0/0", ks_seed, bus.out_data);
    end
`ifdef GRAIN_CTRL_WORD_CNT_EN
    n_tests++;
    if (word_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_word_cnt: got %h want 0", word_cnt);
    end
`endif
  endtask

  task automatic test_keying();
    int acc;
    do_reset(2);
    start = 1'b1; key_in = 80'h1234;
    tick();
    start = 1'b0;
    n_tests++;
    if (ks_load !== 1'b1 || ks_shift !== 1'b0 || ks_seed !== 80'h1234) begin
      n_fail++;
      $display("FAIL load_cycle: load=%b shift=%b seed=%h want 1/0/1234", ks_load, ks_shift,
               ks_seed);
    end
    tick();
    for (int i = 0; i < InitCycles; i++) begin
      n_tests++;
      if (ks_shift !== 1'b1 || ks_load !== 1'b0 || keyed !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL warmup[%0d]: shift=%b load=%b keyed=%b ready=%b want 1/0/0/0", i,
                 ks_shift, ks_load, keyed, bus.in_ready);
      end
      tick();
    end
    n_tests++;
    if (bus.in_ready !== 1'b1 || keyed !== 1'b1 || ks_shift !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: ready=%b keyed=%b shift=%b want 1/1/0", bus.in_ready, keyed,
               ks_shift);
    end
    // start in RUN must not rekey
    start = 1'b1; key_in = 80'hFFFF;
    tick();
    start = 1'b0;
    n_tests++;
    if (ks_seed !== 80'h1234 || ks_load !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run: seed=%h load=%b ready=%b want 1234/0/1", ks_seed, ks_load,
               bus.in_ready);
    end
    run_word(8'h6E, 8'h6E ^ ks_word(80'h1234, InitCycles), 0, acc);
  endtask

  task automatic test_zero_key();
    int acc;
    do_reset(2);
    key_up(80'h0);
    run_word(8'hA5, 8'hA5, 0, acc);
  endtask

  task automatic test_forced_hold();
    int acc;
    do_reset(2);
    force_one = 1'b1;
    key_up(80'h0);
    run_word(8'h3C, 8'hC3, 5, acc);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_handshake: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    force_one = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    do_reset(2);
    key_up(80'h0);
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (ks_shift !== 1'b1) begin
      n_fail++; $display("FAIL xor_active: shift=%b want 1", ks_shift);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({ks_shift, keyed, bus.out_valid, bus.in_ready} !== 4'b0 || ks_seed !== 80'h0) begin
      n_fail++;
      $display("FAIL mid_reset: shift/keyed/valid/ready=%b seed=%h want 0000/0",
               {ks_shift, keyed, bus.out_valid, bus.in_ready}, ks_seed);
    end
    seen = 0;
    repeat (12) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL no_out_after_reset: valid cycles=%0d want 0", seen);
    end
    start = 1'b1; key_in = 80'h1234;
    tick();
    start = 1'b0;
    tick();
    n = 0;
    while (ks_shift === 1'b1 && n < 50) begin tick(); n++; end
    n_tests++;
    if (n != InitCycles || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rewarm: shifts=%0d ready=%b want %0d/1", n, bus.in_ready, InitCycles);
    end
  endtask

  task automatic test_stop();
    int seen;
    do_reset(2);
    key_up(80'h0);
    stop = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
    tick();
    stop = 1'b0; bus.in_valid = 1'b0;
    n_tests++;
    if ({bus.in_ready, keyed, ks_shift} !== 3'b0) begin
      n_fail++;
      $display("FAIL stop_priority: ready/keyed/shift=%b want 000", {bus.in_ready, keyed, ks_shift});
    end
    seen = 0;
    repeat (10) begin
      if (bus.out_valid === 1'b1 || ks_shift === 1'b1) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL stop_idle: active cycles=%0d want 0", seen);
    end
    // start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1; key_in = 80'h55;
    tick();
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (ks_load !== 1'b1 || ks_seed !== 80'h55) begin
      n_fail++; $display("FAIL start_wins: load=%b seed=%h want 1/55", ks_load, ks_seed);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int prev;
    logic [7:0] d;
    do_reset(2);
    key_up(80'h1234);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      d = 8'h5A + 8'(k * 8'h31);
      run_word(d, d ^ ks_word(80'h1234, InitCycles + 8 * k), 0, acc);
      if (k > 0) begin
        n_tests++;
        if (acc - prev != DataW + 2) begin
          n_fail++; $display("FAIL throughput[%0d]: got %0d cycles want %0d", k, acc - prev,
                             DataW + 2);
        end
      end
      prev = acc;
    end
`ifdef GRAIN_CTRL_WORD_CNT_EN
    n_tests++;
    if (word_cnt !== 16'd3) begin
      n_fail++; $display("FAIL word_cnt: got %0d want 3", word_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_keying();
    test_zero_key();
    test_forced_hold();
    test_reset_mid();
    test_stop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
